bp_dma_mem_responder: RTL and testbench

//  Memory-side responder for one L2 bank's bsg_cache DMA interface (dma_pkt / dma_data in / dma_data out).

---
 rtl/bp_dma_mem_responder_pkg.sv | 27 ++
 rtl/bp_dma_mem_responder_mem.sv | 35 +++
 rtl/bp_dma_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_bp_dma_mem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_dma_mem_responder_pkg.sv
// Shared definitions for the DMA memory responder.
//
// Defaults match the single-core L2 bank configuration. The DMA packet
// is carried as a flat vector laid out as {write_not_read, addr}, with
// write_not_read in the MSB and the byte address below it.
package bp_dma_mem_responder_pkg;

  localparam int unsigned resp_daddr_width_default = 28;
  localparam int unsigned resp_fill_width_default  = 64;
  localparam int unsigned resp_block_width_default = 512;
  localparam int unsigned resp_els_default         = 1024;
  localparam int unsigned resp_delay_default       = 4;

  typedef enum logic [1:0] {
    e_idle,
    e_delay,
    e_read,
    e_write
  } resp_state_e;

  // Counter width able to index x values. It never drops below one bit,
  // so a 1-beat block or a 1-cycle delay still gets a real register.
  function automatic int unsigned lg_min1(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_dma_mem_responder_mem.sv
// Backing store for the responder: one write port and one asynchronous read
// port that share a single address.
//
// Ports:
//   clk_i     clock
//   w_v_i     write enable, commits w_data_i at the rising edge
//   addr_i    word index shared by the read and write ports
//   w_data_i  write data
//   r_data_o  combinational read data at addr_i
//
// The array has no reset. Reading a word before it has been written
// returns X in simulation.
module bp_dma_mem_responder_mem #(
  parameter int unsigned width_p = 64,
  parameter int unsigned els_p   = 1024,
  localparam int unsigned lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [lg_els_lp-1:0] addr_i,
  input  logic [width_p-1:0]   w_data_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[addr_i];

endmodule

// File: rtl/bp_dma_mem_responder.sv
// DRAM stand-in below one L2 bank. It accepts a DMA packet, then either
// streams one block of read beats back to the cache or absorbs one block
// of write beats from it. Data is kept in a fill-width word store.
//
// Ports:
//   clk_i                 clock
//   reset_n_i             asynchronous active-low reset
//   dma_pkt_i             {write_not_read, addr}
//   dma_pkt_v_i           packet valid
//   dma_pkt_ready_and_o   packet ready; high only while idle
//   dma_data_o            read beat to the cache
//   dma_data_v_o          read beat valid
//   dma_data_ready_and_i  cache accepts the read beat
//   dma_data_i            write beat from the cache
//   dma_data_v_i          write beat valid
//   dma_data_ready_and_o  responder accepts the write beat
module bp_dma_mem_responder
  import bp_dma_mem_responder_pkg::*;
#(
  parameter int unsigned daddr_width_p = resp_daddr_width_default,
  parameter int unsigned fill_width_p  = resp_fill_width_default,
  parameter int unsigned block_width_p = resp_block_width_default,
  parameter int unsigned els_p         = resp_els_default,
  parameter int unsigned delay_p       = resp_delay_default,
  localparam int unsigned dma_pkt_width_lp = 1 + daddr_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_ready_and_o,
  output logic [fill_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_and_i,
  input  logic [fill_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_and_o
);

  localparam int unsigned lg_fill_bytes_lp = $clog2(fill_width_p / 8);
  localparam int unsigned lg_els_lp        = $clog2(els_p);
  localparam int unsigned beats_lp         = block_width_p / fill_width_p;
  localparam int unsigned beat_w_lp        = lg_min1(beats_lp);
  localparam int unsigned delay_w_lp       = lg_min1(delay_p);

  localparam logic [beat_w_lp-1:0]  beat_last_lp  = beat_w_lp'(beats_lp - 1);
  localparam logic [delay_w_lp-1:0] delay_last_lp = delay_w_lp'((delay_p > 0) ? delay_p - 1 : 0);
  // Clears the beat-offset bits of the word index so that any address
  // inside a block selects the first word of that block.
  localparam logic [lg_els_lp-1:0]  align_mask_lp = ~lg_els_lp'(beats_lp - 1);

  resp_state_e           state_q, state_d;
  logic [beat_w_lp-1:0]  beat_q, beat_d;
  logic [delay_w_lp-1:0] delay_q, delay_d;
  logic [lg_els_lp-1:0]  base_q, base_d;

  logic                  pkt_write_not_read;
  logic [lg_els_lp-1:0]  pkt_index;
  logic [lg_els_lp-1:0]  mem_addr;
  logic                  mem_w_v;
  logic                  pkt_unused;

  assign pkt_write_not_read = dma_pkt_i[dma_pkt_width_lp-1];
  // Address bits above the store index are dropped, so they alias.
  assign pkt_index = dma_pkt_i[lg_fill_bytes_lp +: lg_els_lp];
  // Bits below the word index and above the store index play no role.
  assign pkt_unused = ^dma_pkt_i;

  // The sum wraps modulo els_p.
  assign mem_addr = base_q + lg_els_lp'(beat_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      beat_q  <= '0;
      delay_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      delay_q <= delay_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    delay_d              = delay_q;
    base_d               = base_q;
    dma_pkt_ready_and_o  = 1'b0;
    dma_data_v_o         = 1'b0;
    dma_data_ready_and_o = 1'b0;
    mem_w_v              = 1'b0;

    case (state_q)
      e_idle: begin
        dma_pkt_ready_and_o = 1'b1;
        if (dma_pkt_v_i) begin
          base_d  = pkt_index & align_mask_lp;
          beat_d  = '0;
          delay_d = '0;
          if (pkt_write_not_read) begin
            state_d = e_write;
          end else if (delay_p > 0) begin
            state_d = e_delay;
          end else begin
            state_d = e_read;
          end
        end
      end

      e_delay: begin
        if (delay_q == delay_last_lp) begin
          delay_d = '0;
          state_d = e_read;
        end else begin
          delay_d = delay_q + delay_w_lp'(1);
        end
      end

      e_read: begin
        dma_data_v_o = 1'b1;
        if (dma_data_ready_and_i) begin
          if (beat_q == beat_last_lp) begin
            beat_d  = '0;
            state_d = e_idle;
          end else begin
            beat_d = beat_q + beat_w_lp'(1);
          end
        end
      end

      e_write: begin
        dma_data_ready_and_o = 1'b1;
        if (dma_data_v_i) begin
          mem_w_v = 1'b1;
          if (beat_q == beat_last_lp) begin
            beat_d  = '0;
            state_d = e_idle;
          end else begin
            beat_d = beat_q + beat_w_lp'(1);
          end
        end
      end

      default: state_d = e_idle;
    endcase
  end

  bp_dma_mem_responder_mem #(
    .width_p (fill_width_p),
    .els_p   (els_p)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (mem_w_v),
    .addr_i   (mem_addr),
    .w_data_i (dma_data_i),
    .r_data_o (dma_data_o)
  );

endmodule

// File: tb/tb_bp_dma_mem_responder.sv
// Directed bench for bp_dma_mem_responder. u_dut uses the default
// configuration: 8 beats per block, delay 4, depth 1024. u_dut1 uses a
// 1-beat block with no delay.
module tb_bp_dma_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic [28:0] pkt;
  logic        pkt_v;
  logic        pkt_rdy;
  logic [63:0] rdata;
  logic        rv;
  logic        rready;
  logic [63:0] wdata;
  logic        wv;
  logic        wrdy;

  logic [28:0] pkt1;
  logic        pkt1_v;
  logic        pkt1_rdy;
  logic [63:0] rdata1;
  logic        rv1;
  logic        rready1;
  logic [63:0] wdata1;
  logic        wv1;
  logic        wrdy1;

  int checks   = 0;
  int failures = 0;

  bp_dma_mem_responder u_dut (
    .clk_i                (clk),
    .reset_n_i            (rst_n),
    .dma_pkt_i            (pkt),
    .dma_pkt_v_i          (pkt_v),
    .dma_pkt_ready_and_o  (pkt_rdy),
    .dma_data_o           (rdata),
    .dma_data_v_o         (rv),
    .dma_data_ready_and_i (rready),
    .dma_data_i           (wdata),
    .dma_data_v_i         (wv),
    .dma_data_ready_and_o (wrdy)
  );

  bp_dma_mem_responder #(
    .block_width_p (64),
    .els_p         (16),
    .delay_p       (0)
  ) u_dut1 (
    .clk_i                (clk),
    .reset_n_i            (rst_n),
    .dma_pkt_i            (pkt1),
    .dma_pkt_v_i          (pkt1_v),
    .dma_pkt_ready_and_o  (pkt1_rdy),
    .dma_data_o           (rdata1),
    .dma_data_v_o         (rv1),
    .dma_data_ready_and_i (rready1),
    .dma_data_i           (wdata1),
    .dma_data_v_i         (wv1),
    .dma_data_ready_and_o (wrdy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a packet on u_dut and returns just after the accepting edge.
  task automatic send_pkt(input logic wnr, input logic [27:0] addr);
    int n;
    n     = 0;
    pkt   = {wnr, addr};
    pkt_v = 1'b1;
    while (!pkt_rdy && n < 100) begin
      tick();
      n++;
    end
    check("pkt_ready", 64'(pkt_rdy), 64'd1);
    tick();
    pkt_v = 1'b0;
  endtask

  // Called just after the accepting edge of a read. It checks the first-beat
  // latency and the 8 beats base + k*step.
  task automatic recv_block(input string tag, input logic [63:0] base, input logic [63:0] step);
    int n;
    n = 0;
    while (!rv && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    rready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_beat"}, rdata, base + 64'(k) * step);
      check({tag, "_excl"}, 64'(rv & wrdy), 64'd0);
      tick();
    end
    rready = 1'b0;
    check({tag, "_done_v"}, 64'(rv), 64'd0);
    check({tag, "_done_rdy"}, 64'(pkt_rdy), 64'd1);
  endtask

  task automatic read_block(input string tag, input logic [27:0] addr,
                            input logic [63:0] base, input logic [63:0] step);
    send_pkt(1'b0, addr);
    recv_block(tag, base, step);
  endtask

  task automatic write_block(input logic [27:0] addr, input logic [63:0] base, input logic [63:0] step);
    send_pkt(1'b1, addr);
    for (int k = 0; k < 8; k++) begin
      wdata = base + 64'(k) * step;
      wv    = 1'b1;
      check("wr_ready", 64'(wrdy), 64'd1);
      tick();
    end
    wv = 1'b0;
    check("wr_done_idle", 64'(pkt_rdy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int hs;
    int acc;
    int n;

    rst_n = 1'b0;
    pkt = '0;  pkt_v = 1'b0;  rready = 1'b0;  wdata = '0;  wv = 1'b0;
    pkt1 = '0; pkt1_v = 1'b0; rready1 = 1'b0; wdata1 = '0; wv1 = 1'b0;
    tick();
    tick();
    check("rst_pkt_ready", 64'(pkt_rdy), 64'd1);
    check("rst_data_v", 64'(rv), 64'd0);
    check("rst_wr_ready", 64'(wrdy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Write beats offered while idle are not accepted.
    wv = 1'b1;
    check("idle_wr_ready", 64'(wrdy), 64'd0);
    wv = 1'b0;

    // Write a block, then read it back.
    write_block(28'h40, 64'h11, 64'h11);
    read_block("rd40", 28'h40, 64'h11, 64'h11);

    // Reset while beat 3 of a read is on the bus.
    send_pkt(1'b0, 28'h40);
    n = 0;
    while (!rv && n < 50) begin
      tick();
      n++;
    end
    rready = 1'b1;
    repeat (3) tick();
    check("mid_beat3", rdata, 64'h44);
    rready = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_v", 64'(rv), 64'd0);
    check("mid_rst_rdy", 64'(pkt_rdy), 64'd1);
    tick();
    check("mid_rst_v_next", 64'(rv), 64'd0);
    check("mid_rst_rdy_next", 64'(pkt_rdy), 64'd1);
    rst_n = 1'b1;
    tick();
    read_block("after_rst", 28'h40, 64'h11, 64'h11);

    // Stall the cache: ready follows 1,0,0,1,0,0,...
    send_pkt(1'b0, 28'h40);
    n = 0;
    while (!rv && n < 50) begin
      tick();
      n++;
    end
    got = 0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      rready = (c % 3 == 0);
      check("stall_v", 64'(rv), 64'd1);
      check("stall_beat", rdata, 64'(got + 1) * 64'h11);
      tick();
      if (rready) got++;
    end
    rready = 1'b0;
    check("stall_count", 64'(got), 64'd8);
    check("stall_end_v", 64'(rv), 64'd0);

    // Unaligned address, then an address above the store that aliases.
    read_block("unaligned", 28'h47, 64'h11, 64'h11);
    read_block("alias", 28'h2040, 64'h11, 64'h11);

    // Late write beats, with the next packet held valid the whole time.
    send_pkt(1'b1, 28'h80);
    pkt   = {1'b0, 28'h80};
    pkt_v = 1'b1;
    repeat (10) begin
      check("late_pkt_rdy", 64'(pkt_rdy), 64'd0);
      check("late_wr_rdy", 64'(wrdy), 64'd1);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      wdata = 64'hA0 + 64'(k);
      wv    = 1'b1;
      check("late_beat_pkt_rdy", 64'(pkt_rdy), 64'd0);
      tick();
    end
    wv = 1'b0;
    check("late_bubble_rdy", 64'(pkt_rdy), 64'd1);
    tick();
    check("late_accepted", 64'(pkt_rdy), 64'd0);
    pkt_v = 1'b0;
    recv_block("late_rd", 64'hA0, 64'h1);

    // u_dut1: a 1-beat block with no delay.
    pkt1   = {1'b1, 28'h18};
    pkt1_v = 1'b1;
    check("d1_pkt_rdy", 64'(pkt1_rdy), 64'd1);
    tick();
    pkt1_v = 1'b0;
    wdata1 = 64'hDEAD;
    wv1    = 1'b1;
    check("d1_wr_rdy", 64'(wrdy1), 64'd1);
    tick();
    wv1  = 1'b0;
    pkt1 = {1'b0, 28'h18};
    pkt1_v = 1'b1;
    check("d1_rd_pkt_rdy", 64'(pkt1_rdy), 64'd1);
    tick();
    pkt1_v = 1'b0;
    check("d1_rd_v_now", 64'(rv1), 64'd1);
    check("d1_rd_data", rdata1, 64'hDEAD);
    rready1 = 1'b1;
    tick();
    check("d1_rd_done_v", 64'(rv1), 64'd0);
    check("d1_rd_done_rdy", 64'(pkt1_rdy), 64'd1);

    // Back-to-back reads: one block every 2 cycles.
    pkt1_v = 1'b1;
    hs  = 0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (rv1 && rready1) begin
        hs++;
        check("d1_b2b_data", rdata1, 64'hDEAD);
      end
      if (pkt1_v && pkt1_rdy) acc++;
      tick();
    end
    pkt1_v  = 1'b0;
    rready1 = 1'b0;
    check("d1_b2b_beats", 64'(hs), 64'd5);
    check("d1_b2b_accepts", 64'(acc), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
